// File: rtl/debugger_pkg.sv
// rtl/debugger_pkg.sv - shared debugger encodings and defaults
package debugger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } step_state_e;

  localparam logic STEP_MODE_CYCLE = 1'b0;
  localparam logic STEP_MODE_INSTR = 1'b1;

  localparam int unsigned DEFAULT_MAX_STEP_CYCLES = 16;

endpackage

// File: rtl/cpu_step_controller.sv
// rtl/cpu_step_controller.sv - gates the 6502 clock enable for debugger single-step and free-run
module cpu_step_controller
  import debugger_pkg::*;
#(
  parameter int unsigned MAX_STEP_CYCLES = DEFAULT_MAX_STEP_CYCLES,
  parameter int unsigned COUNT_W         = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start_step,
  input  logic               i_step_mode,
  input  logic               i_run,
  input  logic               i_cpu_sync,
  output logic               o_cpu_ce,
  output logic               o_step_completed,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [COUNT_W-1:0] o_last_step_cycles
);

  localparam logic [COUNT_W-1:0] MAX_CNT = MAX_STEP_CYCLES[COUNT_W-1:0];

  step_state_e        state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               mode_q, mode_d;
  logic               timeout_q, timeout_d;
  logic [COUNT_W-1:0] last_q, last_d;

  logic ce_dec;
  logic done_dec;
  logic started;
  logic at_max;
  logic stop;

  assign started = (count_q != '0);
  assign at_max  = (count_q == MAX_CNT);
  // SYNC in the first RUN cycle is the fetch we are already parked on, so it never stops the step
  assign stop = ((mode_q == STEP_MODE_CYCLE) && started)
             || ((mode_q == STEP_MODE_INSTR) && started && i_cpu_sync)
             || at_max;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    last_d    = last_q;
    ce_dec    = 1'b0;
    done_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ce_dec = i_run;
        if (!i_run && i_start_step) begin
          mode_d    = i_step_mode;
          count_d   = '0;
          timeout_d = 1'b0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        ce_dec = !stop;
        if (!stop) begin
          count_d = count_q + COUNT_W'(1);
        end else begin
          last_d    = count_q;
          timeout_d = at_max && !((mode_q == STEP_MODE_INSTR) && i_cpu_sync);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        done_dec = 1'b1;
        state_d  = i_start_step ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!i_start_step) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      mode_q    <= STEP_MODE_CYCLE;
      timeout_q <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
    end
  end

  // Reset gates the decodes so a free-run request cannot clock the CPU while held in reset
  assign o_cpu_ce           = i_reset_n && ce_dec;
  assign o_step_completed   = i_reset_n && done_dec;
  assign o_busy             = (state_q != ST_IDLE);
  assign o_timeout          = timeout_q;
  assign o_last_step_cycles = last_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// tb/tb_cpu_step_controller.sv - bench for cpu_step_controller against a 6502 instruction-length CPU model
module tb_cpu_step_controller;

  localparam int MAX = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic       run;
  logic       sync;
  logic       ce;
  logic       done;
  logic       busy;
  logic       tmo;
  logic [7:0] last;

  int checks = 0;
  int errors = 0;

  // CPU model: an instruction of L cycles, SYNC high at position 0 (opcode fetch)
  int   pos = 0;
  int   L = 4;
  bit   cpu_rst = 1'b0;
  logic ce_s = 1'b0;

  assign sync = (pos == 0);

  always #5 clk = ~clk;

  always @(negedge clk) ce_s = ce;

  always @(posedge clk) begin
    if (cpu_rst) pos <= 0;
    else if (ce_s && rst_n) pos <= (pos + 1) % L;
  end

  cpu_step_controller #(
    .MAX_STEP_CYCLES(MAX),
    .COUNT_W(8)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_start_step(start),
    .i_step_mode(mode),
    .i_run(run),
    .i_cpu_sync(sync),
    .o_cpu_ce(ce),
    .o_step_completed(done),
    .o_busy(busy),
    .o_timeout(tmo),
    .o_last_step_cycles(last)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cpu_reset();
    cpu_rst = 1'b1;
    @(posedge clk);
    #1 cpu_rst = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge with the controller idle.
  task automatic run_step(input logic m, input int hold_cycles);
    int rem, exp_cyc, exp_to, ce_cnt, edges;
    bit got;
    rem     = L - pos;
    exp_cyc = (m == 1'b1) ? ((rem < MAX) ? rem : MAX) : 1;
    exp_to  = (m == 1'b1 && rem > MAX) ? 1 : 0;
    mode    = m;
    start   = 1'b1;
    ce_cnt  = 0;
    edges   = 0;
    got     = 1'b0;
    while (!got && edges < 100) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        if (ce) ce_cnt++;
        if (edges >= 1) mode = 1'($urandom_range(0, 1));
        @(posedge clk);
        edges++;
      end
    end
    check("step_completed_seen", int'(got), 1);
    check("ce_cycles", ce_cnt, exp_cyc);
    check("latency_edges", edges, exp_cyc + 2);
    check("last_step_cycles", int'(last), exp_cyc);
    check("timeout", int'(tmo), exp_to);
    check("busy_at_pulse", int'(busy), 1);
    check("ce_at_pulse", int'(ce), 0);
    if (m == 1'b1 && exp_to == 0) check("halted_on_sync", int'(sync), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check("hold_no_pulse", int'(done), 0);
      check("hold_ce", int'(ce), 0);
      check("hold_busy", int'(busy), 1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    mode  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_ce", int'(ce), 0);
    check("timeout_kept", int'(tmo), exp_to);
    if (pos == 0) L = $urandom_range(2, 20);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    run   = 1'b1;
    #1;
    check("rst_ce", int'(ce), 0);
    check("rst_pulse", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(tmo), 0);
    check("rst_last", int'(last), 0);
    run = 1'b0;
    #20;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cpu_reset();

    run_step(1'b0, 0);
    L = 4;
    run_step(1'b1, 0);

    L = 40;
    run_step(1'b1, 1);
    cpu_reset();
    L = 5;
    run_step(1'b1, 0);

    L = 16;
    run_step(1'b1, 0);
    L = 17;
    run_step(1'b1, 0);
    cpu_reset();

    run_step(1'b0, 10);

    L     = 6;
    run   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("freerun_ce", int'(ce), 1);
      check("freerun_busy", int'(busy), 0);
      check("freerun_pulse", int'(done), 0);
      @(posedge clk);
      #1;
    end
    run = 1'b0;
    run_step(1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      run_step(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    cpu_reset();
    L     = 10;
    mode  = 1'b1;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midstep_busy", int'(busy), 1);
    check("midstep_ce", int'(ce), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ce", int'(ce), 0);
    check("async_rst_pulse", int'(done), 0);
    check("async_rst_busy", int'(busy), 0);
    start = 1'b0;
    mode  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_ce", int'(ce), 0);
    check("post_rst_pulse", int'(done), 0);
    check("post_rst_timeout", int'(tmo), 0);
    check("post_rst_last", int'(last), 0);
    @(posedge clk);
    #1;
    cpu_reset();
    L = 3;
    run_step(1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
